// File: rtl/regfile_hilo_if.sv
// Bus bundle for the HI/LO register file: two combinational read ports,
// one general write port and the paired HI/LO write port.
interface regfile_hilo_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       RA;
    logic [4:0]       RB;
    logic [4:0]       WR;
    logic [WIDTH-1:0] Din;
    logic             WE;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             HiLoWE;
    logic [WIDTH-1:0] HiIn;
    logic [WIDTH-1:0] LoIn;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    // Requester side (datapath / bench) drives indices and write data.
    modport master (
        output RA, RB, WR, Din, WE, HiLoWE, HiIn, LoIn,
        input  A, B, Hi, Lo
    );

    // Register file side.
    modport slave (
        input  RA, RB, WR, Din, WE, HiLoWE, HiIn, LoIn,
        output A, B, Hi, Lo
    );
endinterface

// File: rtl/regfile_hilo.sv
// 32 x WIDTH general register file with hard-wired zero register, plus
// separate HI/LO registers. Reads are combinational with write-through
// bypass so an operand being written this cycle is visible immediately.
// Reset is synchronous and also masks the read paths while asserted.
module regfile_hilo #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    regfile_hilo_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] lo_d;

    logic [WIDTH-1:0] rd_a_s;
    logic [WIDTH-1:0] rd_b_s;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] lo_s;

    // Next state of the general registers; index 0 is pinned to zero.
    always_comb begin
        regs_d = regs_q;
        if (bus.WE && (bus.WR != 5'd0)) begin
            regs_d[bus.WR] = bus.Din;
        end else begin
            regs_d = regs_q;
        end
        regs_d[0] = ZERO;
    end

    // Next state of HI/LO; both halves always update together.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (bus.HiLoWE) begin
            hi_d = bus.HiIn;
            lo_d = bus.LoIn;
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // State registers; reset wins over any write presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= ZERO;
            end
            hi_q <= ZERO;
            lo_q <= ZERO;
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Read ports with write-through bypass; zero register never bypasses.
    always_comb begin
        rd_a_s = ZERO;
        rd_b_s = ZERO;
        if (rst) begin
            rd_a_s = ZERO;
            rd_b_s = ZERO;
        end else begin
            if (bus.RA == 5'd0) begin
                rd_a_s = ZERO;
            end else if (bus.WE && (bus.WR == bus.RA)) begin
                rd_a_s = bus.Din;
            end else begin
                rd_a_s = regs_q[bus.RA];
            end

            if (bus.RB == 5'd0) begin
                rd_b_s = ZERO;
            end else if (bus.WE && (bus.WR == bus.RB)) begin
                rd_b_s = bus.Din;
            end else begin
                rd_b_s = regs_q[bus.RB];
            end
        end
    end

    // HI/LO view with same-cycle bypass of the incoming product/quotient.
    always_comb begin
        hi_s = ZERO;
        lo_s = ZERO;
        if (rst) begin
            hi_s = ZERO;
            lo_s = ZERO;
        end else if (bus.HiLoWE) begin
            hi_s = bus.HiIn;
            lo_s = bus.LoIn;
        end else begin
            hi_s = hi_q;
            lo_s = lo_q;
        end
    end

    assign bus.A  = rd_a_s;
    assign bus.B  = rd_b_s;
    assign bus.Hi = hi_s;
    assign bus.Lo = lo_s;

endmodule

// File: tb/tb_regfile_hilo.sv
// Self-checking bench for regfile_hilo. Each step drives inputs on the
// falling edge, pushes the expected A/B/Hi/Lo into a scoreboard queue,
// and the owning test task pops and compares shortly afterwards, before
// the next rising edge commits the writes.
module tb_regfile_hilo;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_hilo_if #(.WIDTH(32)) bus ();

    regfile_hilo #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        r;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  wr;
        logic [31:0] din;
        logic        we;
        logic        hl;
        logic [31:0] hin;
        logic [31:0] lin;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ehi;
        logic [31:0] elo;
    } step_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q [$];

    function automatic step_t mk(string n, logic r, logic [4:0] ra, logic [4:0] rb,
                                 logic [4:0] wr, logic [31:0] din, logic we,
                                 logic hl, logic [31:0] hin, logic [31:0] lin,
                                 logic [31:0] ea, logic [31:0] eb,
                                 logic [31:0] ehi, logic [31:0] elo);
        step_t s;
        s.name = n; s.r = r; s.ra = ra; s.rb = rb; s.wr = wr; s.din = din;
        s.we = we; s.hl = hl; s.hin = hin; s.lin = lin;
        s.ea = ea; s.eb = eb; s.ehi = ehi; s.elo = elo;
        return s;
    endfunction

    // Apply one step on the falling edge and queue its expected outputs.
    task automatic drive_step(input step_t s);
        exp_t e;
        @(negedge clk);
        rst        = s.r;
        bus.RA     = s.ra;
        bus.RB     = s.rb;
        bus.WR     = s.wr;
        bus.Din    = s.din;
        bus.WE     = s.we;
        bus.HiLoWE = s.hl;
        bus.HiIn   = s.hin;
        bus.LoIn   = s.lin;
        e.name = s.name; e.a = s.ea; e.b = s.eb; e.hi = s.ehi; e.lo = s.elo;
        exp_q.push_back(e);
        #2;
    endtask

    task automatic test_reset();
        step_t st [$];
        exp_t  e;
        st.push_back(mk("rst_hold",    1'b1, 5'd5, 5'd5,  5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'h1111, 32'h2222, 32'h0, 32'h0, 32'h0, 32'h0));
        st.push_back(mk("rst_release", 1'b0, 5'd5, 5'd31, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,    32'h0, 32'h0, 32'h0, 32'h0));
        st.push_back(mk("rst_idle",    1'b0, 5'd6, 5'd1,  5'd0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,    32'h0, 32'h0, 32'h0, 32'h0));
        foreach (st[i]) begin
            drive_step(st[i]);
            e = exp_q.pop_front();
            checks++; if (bus.A  !== e.a)  begin errors++; $display("FAIL %s A got %h exp %h",  e.name, bus.A,  e.a);  end
            checks++; if (bus.B  !== e.b)  begin errors++; $display("FAIL %s B got %h exp %h",  e.name, bus.B,  e.b);  end
            checks++; if (bus.Hi !== e.hi) begin errors++; $display("FAIL %s Hi got %h exp %h", e.name, bus.Hi, e.hi); end
            checks++; if (bus.Lo !== e.lo) begin errors++; $display("FAIL %s Lo got %h exp %h", e.name, bus.Lo, e.lo); end
        end
    endtask

    task automatic test_bypass();
        step_t st [$];
        exp_t  e;
        st.push_back(mk("byp_write",  1'b0, 5'd3, 5'd0, 5'd3, 32'h80000000, 1'b1, 1'b0, 32'h0, 32'h0, 32'h80000000, 32'h0,        32'h0, 32'h0));
        st.push_back(mk("byp_stored", 1'b0, 5'd3, 5'd3, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 32'h80000000, 32'h80000000, 32'h0, 32'h0));
        foreach (st[i]) begin
            drive_step(st[i]);
            e = exp_q.pop_front();
            checks++; if (bus.A  !== e.a)  begin errors++; $display("FAIL %s A got %h exp %h",  e.name, bus.A,  e.a);  end
            checks++; if (bus.B  !== e.b)  begin errors++; $display("FAIL %s B got %h exp %h",  e.name, bus.B,  e.b);  end
            checks++; if (bus.Hi !== e.hi) begin errors++; $display("FAIL %s Hi got %h exp %h", e.name, bus.Hi, e.hi); end
            checks++; if (bus.Lo !== e.lo) begin errors++; $display("FAIL %s Lo got %h exp %h", e.name, bus.Lo, e.lo); end
        end
    endtask

    task automatic test_reg0();
        step_t st [$];
        exp_t  e;
        st.push_back(mk("r0_write", 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,        32'h0, 32'h0, 32'h0));
        st.push_back(mk("r0_after", 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 32'h0,        32'h0, 32'h0, 32'h0));
        st.push_back(mk("r0_mixed", 1'b0, 5'd3, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 32'h80000000, 32'h0, 32'h0, 32'h0));
        foreach (st[i]) begin
            drive_step(st[i]);
            e = exp_q.pop_front();
            checks++; if (bus.A  !== e.a)  begin errors++; $display("FAIL %s A got %h exp %h",  e.name, bus.A,  e.a);  end
            checks++; if (bus.B  !== e.b)  begin errors++; $display("FAIL %s B got %h exp %h",  e.name, bus.B,  e.b);  end
            checks++; if (bus.Hi !== e.hi) begin errors++; $display("FAIL %s Hi got %h exp %h", e.name, bus.Hi, e.hi); end
            checks++; if (bus.Lo !== e.lo) begin errors++; $display("FAIL %s Lo got %h exp %h", e.name, bus.Lo, e.lo); end
        end
    endtask

    task automatic test_operands();
        step_t st [$];
        exp_t  e;
        st.push_back(mk("op_wr4",      1'b0, 5'd3, 5'd4, 5'd4, 32'd3, 1'b1, 1'b0, 32'h0, 32'h0, 32'h80000000, 32'd3, 32'h0, 32'h0));
        st.push_back(mk("op_pair",     1'b0, 5'd3, 5'd4, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h80000000, 32'd3, 32'h0, 32'h0));
        st.push_back(mk("op_byp_b",    1'b0, 5'd3, 5'd4, 5'd4, 32'd7, 1'b1, 1'b0, 32'h0, 32'h0, 32'h80000000, 32'd7, 32'h0, 32'h0));
        st.push_back(mk("op_same",     1'b0, 5'd4, 5'd4, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd7,        32'd7, 32'h0, 32'h0));
        st.push_back(mk("op_same_byp", 1'b0, 5'd4, 5'd4, 5'd4, 32'd9, 1'b1, 1'b0, 32'h0, 32'h0, 32'd9,        32'd9, 32'h0, 32'h0));
        st.push_back(mk("op_same_st",  1'b0, 5'd4, 5'd4, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd9,        32'd9, 32'h0, 32'h0));
        foreach (st[i]) begin
            drive_step(st[i]);
            e = exp_q.pop_front();
            checks++; if (bus.A  !== e.a)  begin errors++; $display("FAIL %s A got %h exp %h",  e.name, bus.A,  e.a);  end
            checks++; if (bus.B  !== e.b)  begin errors++; $display("FAIL %s B got %h exp %h",  e.name, bus.B,  e.b);  end
            checks++; if (bus.Hi !== e.hi) begin errors++; $display("FAIL %s Hi got %h exp %h", e.name, bus.Hi, e.hi); end
            checks++; if (bus.Lo !== e.lo) begin errors++; $display("FAIL %s Lo got %h exp %h", e.name, bus.Lo, e.lo); end
        end
    endtask

    task automatic test_hilo();
        step_t st [$];
        exp_t  e;
        st.push_back(mk("hl_write",  1'b0, 5'd8, 5'd4, 5'd8, 32'h1234, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h80000000, 32'h1234, 32'd9,        32'hFFFFFFFF, 32'h80000000));
        st.push_back(mk("hl_hold1",  1'b0, 5'd8, 5'd3, 5'd0, 32'h0,    1'b0, 1'b0, 32'h1,        32'h2,        32'h1234, 32'h80000000, 32'hFFFFFFFF, 32'h80000000));
        st.push_back(mk("hl_hold2",  1'b0, 5'd8, 5'd3, 5'd0, 32'h0,    1'b0, 1'b0, 32'h3,        32'h4,        32'h1234, 32'h80000000, 32'hFFFFFFFF, 32'h80000000));
        st.push_back(mk("hl_write2", 1'b0, 5'd8, 5'd8, 5'd0, 32'h0,    1'b0, 1'b1, 32'h5,        32'h6,        32'h1234, 32'h1234,     32'h5,        32'h6));
        st.push_back(mk("hl_stored", 1'b0, 5'd8, 5'd8, 5'd0, 32'h0,    1'b0, 1'b0, 32'h7,        32'h8,        32'h1234, 32'h1234,     32'h5,        32'h6));
        foreach (st[i]) begin
            drive_step(st[i]);
            e = exp_q.pop_front();
            checks++; if (bus.A  !== e.a)  begin errors++; $display("FAIL %s A got %h exp %h",  e.name, bus.A,  e.a);  end
            checks++; if (bus.B  !== e.b)  begin errors++; $display("FAIL %s B got %h exp %h",  e.name, bus.B,  e.b);  end
            checks++; if (bus.Hi !== e.hi) begin errors++; $display("FAIL %s Hi got %h exp %h", e.name, bus.Hi, e.hi); end
            checks++; if (bus.Lo !== e.lo) begin errors++; $display("FAIL %s Lo got %h exp %h", e.name, bus.Lo, e.lo); end
        end
    endtask

    task automatic test_reset_mid();
        step_t st [$];
        exp_t  e;
        st.push_back(mk("mid_rst",    1'b1, 5'd3, 5'd4, 5'd6, 32'd9, 1'b1, 1'b1, 32'hAAAA, 32'h5555, 32'h0,  32'h0, 32'h0, 32'h0));
        st.push_back(mk("mid_clr34",  1'b0, 5'd3, 5'd4, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0,    32'h0,    32'h0,  32'h0, 32'h0, 32'h0));
        st.push_back(mk("mid_clr68",  1'b0, 5'd6, 5'd8, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0,    32'h0,    32'h0,  32'h0, 32'h0, 32'h0));
        st.push_back(mk("mid_first",  1'b0, 5'd6, 5'd1, 5'd6, 32'd9, 1'b1, 1'b0, 32'h0,    32'h0,    32'd9,  32'h0, 32'h0, 32'h0));
        st.push_back(mk("mid_stored", 1'b0, 5'd6, 5'd6, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0,    32'h0,    32'd9,  32'd9, 32'h0, 32'h0));
        foreach (st[i]) begin
            drive_step(st[i]);
            e = exp_q.pop_front();
            checks++; if (bus.A  !== e.a)  begin errors++; $display("FAIL %s A got %h exp %h",  e.name, bus.A,  e.a);  end
            checks++; if (bus.B  !== e.b)  begin errors++; $display("FAIL %s B got %h exp %h",  e.name, bus.B,  e.b);  end
            checks++; if (bus.Hi !== e.hi) begin errors++; $display("FAIL %s Hi got %h exp %h", e.name, bus.Hi, e.hi); end
            checks++; if (bus.Lo !== e.lo) begin errors++; $display("FAIL %s Lo got %h exp %h", e.name, bus.Lo, e.lo); end
        end
    endtask

    // Random traffic checked against a behavioural model of the register file.
    task automatic test_random();
        logic [31:0] mdl [32];
        logic [31:0] mhi;
        logic [31:0] mlo;
        step_t       s;
        exp_t        e;
        for (int n = 0; n < 200; n++) begin
            s.name = "rand";
            s.r    = (n == 0) || ($urandom_range(0, 19) == 0);
            s.ra   = 5'($urandom_range(0, 31));
            s.rb   = ($urandom_range(0, 3) == 0) ? s.ra : 5'($urandom_range(0, 31));
            s.wr   = ($urandom_range(0, 2) == 0) ? s.ra : 5'($urandom_range(0, 31));
            s.din  = $urandom;
            s.we   = 1'($urandom_range(0, 1));
            s.hl   = ($urandom_range(0, 3) == 0);
            s.hin  = $urandom;
            s.lin  = $urandom;
            if (s.r) begin
                s.ea = 32'h0; s.eb = 32'h0; s.ehi = 32'h0; s.elo = 32'h0;
            end else begin
                if (s.ra == 5'd0)                      s.ea = 32'h0;
                else if (s.we && (s.wr == s.ra))       s.ea = s.din;
                else                                   s.ea = mdl[s.ra];
                if (s.rb == 5'd0)                      s.eb = 32'h0;
                else if (s.we && (s.wr == s.rb))       s.eb = s.din;
                else                                   s.eb = mdl[s.rb];
                s.ehi = s.hl ? s.hin : mhi;
                s.elo = s.hl ? s.lin : mlo;
            end
            drive_step(s);
            e = exp_q.pop_front();
            checks++; if (bus.A  !== e.a)  begin errors++; $display("FAIL %s%0d A got %h exp %h",  e.name, n, bus.A,  e.a);  end
            checks++; if (bus.B  !== e.b)  begin errors++; $display("FAIL %s%0d B got %h exp %h",  e.name, n, bus.B,  e.b);  end
            checks++; if (bus.Hi !== e.hi) begin errors++; $display("FAIL %s%0d Hi got %h exp %h", e.name, n, bus.Hi, e.hi); end
            checks++; if (bus.Lo !== e.lo) begin errors++; $display("FAIL %s%0d Lo got %h exp %h", e.name, n, bus.Lo, e.lo); end
            // Model the upcoming rising edge.
            if (s.r) begin
                for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
                mhi = 32'h0;
                mlo = 32'h0;
            end else begin
                if (s.we && (s.wr != 5'd0)) mdl[s.wr] = s.din;
                if (s.hl) begin
                    mhi = s.hin;
                    mlo = s.lin;
                end
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.RA     = 5'd0;
        bus.RB     = 5'd0;
        bus.WR     = 5'd0;
        bus.Din    = 32'h0;
        bus.WE     = 1'b0;
        bus.HiLoWE = 1'b0;
        bus.HiIn   = 32'h0;
        bus.LoIn   = 32'h0;
        test_reset();
        test_bypass();
        test_reg0();
        test_operands();
        test_hilo();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_hilo.md
REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 Parameter WIDTH, default 32, data width of every general register, HI, LO and data port.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 RA  input  5  read-port-A register index (feeds ALU X).
REQ-005 RB  input  5  read-port-B register index (feeds ALU Y).
REQ-006 WR  input  5  write-port register index.
REQ-007 Din  input  WIDTH  write data for general register WR.
REQ-008 WE  input  1  general-register write enable.
REQ-009 A  output  WIDTH  read data for RA (to ALU X).
REQ-010 B  output  WIDTH  read data for RB (to ALU Y).
REQ-011 HiLoWE  input  1  HI/LO write enable (multiply/divide completion).
REQ-012 HiIn  input  WIDTH  HI write data (from ALU Result2).
REQ-013 LoIn  input  WIDTH  LO write data (from ALU Result).
REQ-014 Hi  output  WIDTH  current HI value.
REQ-015 Lo  output  WIDTH  current LO value.

Function
REQ-016 Storage SHALL be 32 general registers of WIDTH bits plus separate HI and LO registers of WIDTH bits.
REQ-017 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded.
REQ-018 General-register write SHALL occur on the rising edge when WE=1 and rst=0: reg[WR] <= Din.
REQ-019 HI/LO write SHALL occur on the rising edge when HiLoWE=1 and rst=0: HI <= HiIn, LO <= LoIn, both in the same edge.
REQ-020 General and HI/LO writes SHALL be independent; both may occur on the same edge.
REQ-021 Reads SHALL be combinational (zero-cycle latency) from RA/RB to A/B.
REQ-022 Write-through bypass: when rst=0, WE=1, WR!=0 and WR==RA, A SHALL equal Din in the same cycle; likewise B when WR==RB.
REQ-023 RA==RB SHALL return identical data on A and B, bypass included.
REQ-024 HI/LO bypass: when rst=0 and HiLoWE=1, Hi SHALL equal HiIn and Lo SHALL equal LoIn in the same cycle; otherwise they show stored values.
REQ-025 Write to index 0 with WE=1 SHALL NOT bypass; A/B for index 0 remain 0.
REQ-026 No storage element SHALL change on an edge where its write enable is 0.

Reset
REQ-027 On a rising edge with rst=1, all 32 general registers, HI and LO SHALL become 0.
REQ-028 rst SHALL have priority over WE and HiLoWE; writes presented during a reset edge are discarded.
REQ-029 While rst=1, A, B, Hi and Lo SHALL read 0 and both bypass paths SHALL be disabled.
REQ-030 Reset asserted mid-sequence (after prior writes) SHALL clear all prior contents in one edge; first write after deassertion behaves normally.
REQ-031 Before the first reset edge, contents are undefined; the bench SHALL reset before checking.

Verification
REQ-032 Reset 1 cycle, then RA=5, RB=31 -> A=0, B=0, Hi=0, Lo=0.
REQ-033 WE=1, WR=3, Din=32'h80000000, RA=3 same cycle -> A=32'h80000000 before edge (bypass); after edge with WE=0, A=32'h80000000 (stored).
REQ-034 WE=1, WR=0, Din=32'hFFFFFFFF, RA=0, RB=0 -> A=0, B=0 before and after edge.
REQ-035 Write reg 4=32'd3, then RA=3, RB=4 -> A=32'h80000000, B=32'd3 (ALU operand pair); WE=1, WR=4, Din=7 same cycle as RB=4 -> B=7.
REQ-036 HiLoWE=1, HiIn=32'hFFFFFFFF, LoIn=32'h80000000 -> Hi/Lo show those values same cycle and after edge; next cycle HiLoWE=0 with new HiIn/LoIn -> unchanged.
REQ-037 After REQ-033..036, rst=1 with WE=1, WR=6, Din=9, HiLoWE=1 for one edge -> reg 3, reg 4, reg 6, HI, LO all read 0 after deassertion.
